// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter with one-entry holding buffers and a registered register-file write port.
// Optional WB_ZERO_REG_FILTER_EN: a granted write to address 0 is consumed but never asserts we_o.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  src0_valid_i,
    output logic                  src0_ready_o,
    input  logic [ADDR_WIDTH-1:0] src0_addr_i,
    input  logic [DATA_WIDTH-1:0] src0_data_i,
    input  logic                  src1_valid_i,
    output logic                  src1_ready_o,
    input  logic [ADDR_WIDTH-1:0] src1_addr_i,
    input  logic [DATA_WIDTH-1:0] src1_data_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  pending_o
);

    logic                  full0_q, full0_d, full1_q, full1_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  rr_q, rr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  gnt0, gnt1, acc0, acc1;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;

    // rr_q = 0 favours source 0 when both buffers are full
    assign gnt0 = full0_q & (~full1_q | ~rr_q);
    assign gnt1 = full1_q & (~full0_q | rr_q);

    assign src0_ready_o = ~rst_i & (~full0_q | gnt0);
    assign src1_ready_o = ~rst_i & (~full1_q | gnt1);
    assign acc0 = src0_valid_i & src0_ready_o;
    assign acc1 = src1_valid_i & src1_ready_o;

    assign gnt_addr = gnt0 ? addr0_q : addr1_q;
    assign gnt_data = gnt0 ? data0_q : data1_q;

    always_comb begin
        full0_d = full0_q;
        addr0_d = addr0_q;
        data0_d = data0_q;
        full1_d = full1_q;
        addr1_d = addr1_q;
        data1_d = data1_q;
        rr_d    = rr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (acc0) begin
            full0_d = 1'b1;
            addr0_d = src0_addr_i;
            data0_d = src0_data_i;
        end else if (gnt0) begin
            full0_d = 1'b0;
        end

        if (acc1) begin
            full1_d = 1'b1;
            addr1_d = src1_addr_i;
            data1_d = src1_data_i;
        end else if (gnt1) begin
            full1_d = 1'b0;
        end

        if (full0_q && full1_q) begin
            rr_d = gnt0;
        end

`ifdef WB_ZERO_REG_FILTER_EN
        we_d = (gnt0 | gnt1) & (gnt_addr != '0);
`else
        we_d = gnt0 | gnt1;
`endif
        if (we_d) begin
            waddr_d = gnt_addr;
            wdata_d = gnt_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full0_q <= 1'b0;
            addr0_q <= '0;
            data0_q <= '0;
            full1_q <= 1'b0;
            addr1_q <= '0;
            data1_q <= '0;
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            full0_q <= full0_d;
            addr0_q <= addr0_d;
            data0_q <= data0_d;
            full1_q <= full1_d;
            addr1_q <= addr1_d;
            data1_q <= data1_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o      = we_q;
    assign waddr_o   = waddr_q;
    assign wdata_o   = wdata_q;
    assign pending_o = full0_q | full1_q | we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; the write port feeds a small register-file model.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          src0_valid_i = 1'b0, src1_valid_i = 1'b0;
    logic          src0_ready_o, src1_ready_o;
    logic [AW-1:0] src0_addr_i = '0, src1_addr_i = '0;
    logic [DW-1:0] src0_data_i = '0, src1_data_i = '0;
    logic          we_o, pending_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];
    logic [DW-1:0] rf[32];

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .src0_valid_i(src0_valid_i), .src0_ready_o(src0_ready_o),
        .src0_addr_i(src0_addr_i), .src0_data_i(src0_data_i),
        .src1_valid_i(src1_valid_i), .src1_ready_o(src1_ready_o),
        .src1_addr_i(src1_addr_i), .src1_data_i(src1_data_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    // Write-port monitor and register-file model
    always @(negedge clk_i) begin
        cyc++;
        if (we_o === 1'b1) begin
            log_addr.push_back(waddr_o);
            log_data.push_back(wdata_o);
            log_cyc.push_back(cyc);
            rf[waddr_o] = wdata_o;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        src0_valid_i = 1'b0;
        src1_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        src0_valid_i = 1'b1;
        src1_valid_i = 1'b1;
        #1;
        checks++;
        if (src0_ready_o !== 1'b0 || src1_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", src0_ready_o, src1_ready_o);
        end
        step();
        step();
        src0_valid_i = 1'b0;
        src1_valid_i = 1'b0;
        rst_i = 1'b0;
        checks++;
        if (we_o !== 1'b0 || waddr_o !== '0 || wdata_o !== '0 || pending_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b waddr=%0d wdata=%h pend=%b expected 0 0 0 0",
                     we_o, waddr_o, wdata_o, pending_o);
        end
        step();
        checks++;
        if (pending_o !== 1'b0 || src0_ready_o !== 1'b1 || src1_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got pend=%b rdy=%b%b expected 0 11",
                     pending_o, src0_ready_o, src1_ready_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        src0_valid_i = 1'b1;
        src0_addr_i  = 5'd3;
        src0_data_i  = 32'h11;
        step();
        src0_valid_i = 1'b0;
        checks++;
        if (we_o !== 1'b0 || pending_o !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got we=%b pend=%b expected we=0 pend=1", we_o, pending_o);
        end
        step();
        checks++;
        if (we_o !== 1'b1 || waddr_o !== 5'd3 || wdata_o !== 32'h11) begin
            errors++;
            $display("FAIL single_write: got we=%b waddr=%0d wdata=%h expected 1 3 11", we_o, waddr_o, wdata_o);
        end
        step();
        checks++;
        if (we_o !== 1'b0 || waddr_o !== 5'd3 || wdata_o !== 32'h11 || pending_o !== 1'b0) begin
            errors++;
            $display("FAIL single_after: got we=%b waddr=%0d wdata=%h pend=%b expected 0 3 11 0",
                     we_o, waddr_o, wdata_o, pending_o);
        end
    endtask

    task automatic test_contention();
        do_reset();
        src0_valid_i = 1'b1; src0_addr_i = 5'd5; src0_data_i = 32'hA5;
        src1_valid_i = 1'b1; src1_addr_i = 5'd6; src1_data_i = 32'hB6;
        step();
        src0_valid_i = 1'b0;
        src1_valid_i = 1'b0;
        checks++;
        if (src0_ready_o !== 1'b1 || src1_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL contend_ready: got %b%b expected 10", src0_ready_o, src1_ready_o);
        end
        step();
        checks++;
        if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'hA5 || src1_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL contend_first: got we=%b waddr=%0d wdata=%h rdy1=%b expected 1 5 a5 1",
                     we_o, waddr_o, wdata_o, src1_ready_o);
        end
        step();
        checks++;
        if (we_o !== 1'b1 || waddr_o !== 5'd6 || wdata_o !== 32'hB6) begin
            errors++;
            $display("FAIL contend_second: got we=%b waddr=%0d wdata=%h expected 1 6 b6", we_o, waddr_o, wdata_o);
        end
        step();
        checks++;
        if (we_o !== 1'b0 || pending_o !== 1'b0) begin
            errors++;
            $display("FAIL contend_idle: got we=%b pend=%b expected 0 0", we_o, pending_o);
        end
    endtask

    task automatic test_stream();
        int  i0 = 0, i1 = 0, n = 0;
        logic a0, a1;
        do_reset();
        clear_log();
        while ((i0 < 4 || i1 < 4) && n < 40) begin
            src0_valid_i = (i0 < 4);
            src0_addr_i  = AW'(8 + i0);
            src0_data_i  = 32'h100 + DW'(i0);
            src1_valid_i = (i1 < 4);
            src1_addr_i  = AW'(12 + i1);
            src1_data_i  = 32'h200 + DW'(i1);
            #3;
            a0 = src0_valid_i & src0_ready_o;
            a1 = src1_valid_i & src1_ready_o;
            step();
            if (a0) i0++;
            if (a1) i1++;
            n++;
        end
        src0_valid_i = 1'b0;
        src1_valid_i = 1'b0;
        checks++;
        if (i0 != 4 || i1 != 4) begin
            errors++;
            $display("FAIL stream_accept_timeout: got %0d/%0d accepted expected 4/4", i0, i1);
        end
        repeat (4) step();
        checks++;
        if (log_addr.size() != 8) begin
            errors++;
            $display("FAIL stream_count: got %0d writes expected 8", log_addr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                logic [AW-1:0] ea;
                logic [DW-1:0] ed;
                ea = (k % 2 == 0) ? AW'(8 + k / 2) : AW'(12 + k / 2);
                ed = (k % 2 == 0) ? 32'h100 + DW'(k / 2) : 32'h200 + DW'(k / 2);
                checks++;
                if (log_addr[k] !== ea || log_data[k] !== ed) begin
                    errors++;
                    $display("FAIL stream_order[%0d]: got %0d/%h expected %0d/%h", k, log_addr[k], log_data[k], ea, ed);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_log();
        src0_valid_i = 1'b1; src0_addr_i = 5'd20; src0_data_i = 32'h55;
        src1_valid_i = 1'b1; src1_addr_i = 5'd21; src1_data_i = 32'h66;
        step();
        src0_valid_i = 1'b0;
        src1_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if (src0_ready_o !== 1'b0 || src1_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: got %b%b expected 00", src0_ready_o, src1_ready_o);
        end
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (pending_o !== 1'b0 || we_o !== 1'b0 || src0_ready_o !== 1'b1 || src1_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: got pend=%b we=%b rdy=%b%b expected 0 0 11",
                     pending_o, we_o, src0_ready_o, src1_ready_o);
        end
        repeat (3) step();
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL midreset_nowrite: got %0d writes expected 0", log_addr.size());
        end
    endtask

    task automatic test_zero_addr();
        logic exp_we;
`ifdef WB_ZERO_REG_FILTER_EN
        exp_we = 1'b0;
`else
        exp_we = 1'b1;
`endif
        do_reset();
        src1_valid_i = 1'b1; src1_addr_i = 5'd0; src1_data_i = 32'h77;
        step();
        src1_valid_i = 1'b0;
        step();
        checks++;
        if (we_o !== exp_we || src1_ready_o !== 1'b1 || pending_o !== exp_we) begin
            errors++;
            $display("FAIL zero_addr: got we=%b rdy1=%b pend=%b expected %b 1 %b",
                     we_o, src1_ready_o, pending_o, exp_we, exp_we);
        end
        if (exp_we) begin
            checks++;
            if (waddr_o !== 5'd0 || wdata_o !== 32'h77) begin
                errors++;
                $display("FAIL zero_addr_data: got %0d/%h expected 0/77", waddr_o, wdata_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        int i = 0, n = 0, first;
        logic a0;
        do_reset();
        clear_log();
        for (int k = 0; k < 32; k++) rf[k] = '0;
        while (i < 32 && n < 50) begin
            src0_valid_i = 1'b1;
            src0_addr_i  = AW'(i);
            src0_data_i  = DW'(i + 1);
            #3;
            a0 = src0_ready_o;
            step();
            if (a0) i++;
            n++;
        end
        src0_valid_i = 1'b0;
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL b2b_ready: got %0d cycles for 32 accepts expected 32", n);
        end
        repeat (3) step();
`ifdef WB_ZERO_REG_FILTER_EN
        first = 1;
`else
        first = 0;
`endif
        checks++;
        if (log_addr.size() != 32 - first) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes expected %0d", log_addr.size(), 32 - first);
        end else begin
            for (int k = 0; k < 32 - first; k++) begin
                checks++;
                if (log_addr[k] !== AW'(k + first) || log_cyc[k] != log_cyc[0] + k) begin
                    errors++;
                    $display("FAIL b2b_seq[%0d]: got addr %0d cyc %0d expected addr %0d cyc %0d",
                             k, log_addr[k], log_cyc[k], k + first, log_cyc[0] + k);
                end
            end
        end
        for (int k = first; k < 32; k++) begin
            logic [DW-1:0] rd_a, rd_b;
            rd_a = rf[k];
            rd_b = rf[31 - k + first];
            checks++;
            if (rd_a !== DW'(k + 1) || rd_b !== DW'(32 - k + first)) begin
                errors++;
                $display("FAIL b2b_readback[%0d]: got %h/%h expected %h/%h",
                         k, rd_a, rd_b, k + 1, 32 - k + first);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stream();
        test_reset_mid();
        test_zero_addr();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
